dtree_vote_engine: RTL and testbench

//  Sequential, reprogrammable successor to the hard-wired per-class mux trees. Evaluates NUM_TREES binary decision

---
 rtl/dtree_pkg.sv | 36 +++
 rtl/dtree_node_table.sv | 25 ++
 rtl/dtree_vote_engine.sv | 143 ++++++++++++++
 tb/tb_dtree_vote_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared types and width helpers for the decision-tree vote engine.
// Node word layout, MSB first: {leaf, fidx, lo, hi}.
package dtree_pkg;

  localparam int FEAT_W_DEF    = 51;
  localparam int TREE_AW_DEF   = 6;
  localparam int TIE_CLASS_DEF = 0;

  function automatic int fi_w(input int feat_w);
    return (feat_w > 1) ? $clog2(feat_w) : 1;
  endfunction

  function automatic int node_w(input int feat_w, input int tree_aw);
    return 1 + fi_w(feat_w) + 2 * tree_aw;
  endfunction

  function automatic int votes_w(input int num_trees);
    return $clog2(num_trees + 1);
  endfunction

  localparam int FI_W_DEF = fi_w(FEAT_W_DEF);

  typedef struct packed {
    logic                   leaf;
    logic [FI_W_DEF-1:0]    fidx;
    logic [TREE_AW_DEF-1:0] lo;
    logic [TREE_AW_DEF-1:0] hi;
  } node_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WALK,
    S_DONE
  } state_e;

endpackage

// File: rtl/dtree_node_table.sv
// Node table for all trees: one synchronous write port, one asynchronous read port.
// Contents survive reset so a programmed model outlives an engine restart.
module dtree_node_table #(
  parameter int AW     = 8,
  parameter int DEPTH  = 256,
  parameter int NODE_W = 19
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [NODE_W-1:0] rdata
);

  logic [NODE_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array; resetting it would turn it into flops with a huge reset fan-out and erase the model.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dtree_vote_engine.sv
// Walks NUM_TREES decision trees, one node per clock, over a latched feature vector
// and majority-votes the binary leaf results into a single class bit.
module dtree_vote_engine
  import dtree_pkg::*;
#(
  parameter int FEAT_W    = FEAT_W_DEF,
  parameter int NUM_TREES = 4,
  parameter int TREE_AW   = TREE_AW_DEF,
  parameter int MAX_STEPS = 16,
  parameter int TIE_CLASS = TIE_CLASS_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [FEAT_W-1:0]                    in_feat,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_class,
  output logic [votes_w(NUM_TREES)-1:0]        out_votes,
  output logic                                 out_err,
  input  logic                                 cfg_we,
  input  logic [$clog2(NUM_TREES)+TREE_AW-1:0] cfg_addr,
  input  logic [node_w(FEAT_W, TREE_AW)-1:0]   cfg_wdata,
  output logic                                 cfg_busy
);

  localparam int FI_W   = fi_w(FEAT_W);
  localparam int NODE_W = node_w(FEAT_W, TREE_AW);
  localparam int VW     = votes_w(NUM_TREES);
  localparam int CAW    = $clog2(NUM_TREES) + TREE_AW;
  localparam int TW     = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
  localparam int SW     = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  state_e              state_q, state_d;
  logic [FEAT_W-1:0]   feat_q;
  logic [TW-1:0]       tree_q;
  logic [TREE_AW-1:0]  node_q;
  logic [SW-1:0]       steps_q;
  logic [VW-1:0]       votes_q;
  logic                err_q;

  logic [CAW-1:0]      rd_addr;
  logic [NODE_W-1:0]   rd_word;
  logic                is_leaf, feat_bit, abort, tree_done, last_tree, leaf_vote, class_nx;
  logic [FI_W-1:0]     fidx;
  logic [TREE_AW-1:0]  lo, hi, next_node;
  logic [VW-1:0]       votes_nx;

  dtree_node_table #(
    .AW     (CAW),
    .DEPTH  (NUM_TREES << TREE_AW),
    .NODE_W (NODE_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && (state_q == S_IDLE)),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  assign rd_addr   = CAW'({tree_q, node_q});
  assign is_leaf   = rd_word[NODE_W-1];
  assign fidx      = rd_word[NODE_W-2 -: FI_W];
  assign lo        = rd_word[2*TREE_AW-1 -: TREE_AW];
  assign hi        = rd_word[TREE_AW-1:0];
  // Out-of-range feature indices select a constant 0 rather than aliasing a real bit.
  assign feat_bit  = (int'(fidx) < FEAT_W) ? feat_q[fidx] : 1'b0;
  assign next_node = feat_bit ? hi : lo;
  assign abort     = !is_leaf && (steps_q == SW'(MAX_STEPS - 1));
  assign tree_done = is_leaf || abort;
  assign last_tree = (tree_q == TW'(NUM_TREES - 1));
  assign leaf_vote = is_leaf & lo[0];
  assign votes_nx  = votes_q + VW'(leaf_vote);

  assign in_ready  = (state_q == S_IDLE);
  assign cfg_busy  = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: combinational blocks assign every output a default first so no path leaves a value held, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    class_nx = TIE_CLASS[0];
    if (int'(votes_nx) * 2 > NUM_TREES)      class_nx = 1'b1;
    else if (int'(votes_nx) * 2 < NUM_TREES) class_nx = 1'b0;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_WALK;
      S_WALK:  if (tree_done && last_tree) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      feat_q    <= '0;
      tree_q    <= '0;
      node_q    <= '0;
      steps_q   <= '0;
      votes_q   <= '0;
      err_q     <= 1'b0;
      out_class <= 1'b0;
      out_votes <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          feat_q  <= in_feat;
          tree_q  <= '0;
          node_q  <= '0;
          steps_q <= '0;
          votes_q <= '0;
          err_q   <= 1'b0;
        end
        S_WALK: if (tree_done) begin
          votes_q <= votes_nx;
          err_q   <= err_q | abort;
          if (last_tree) begin
            out_votes <= votes_nx;
            out_class <= class_nx;
            out_err   <= err_q | abort;
          end else begin
            tree_q  <= tree_q + 1'b1;
            node_q  <= '0;
            steps_q <= '0;
          end
        end else begin
          node_q  <= next_node;
          steps_q <= steps_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_vote_engine.sv
// Directed bench: two engines (TIE_CLASS 0 and 1) share all inputs and are checked every
// cycle against a transaction-level tree-walk model, plus hand-computed literal results.
module tb_dtree_vote_engine;
  import dtree_pkg::*;

  typedef struct packed {
    int visits;
    int votes;
    bit err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cfg_we;
  logic [50:0] in_feat;
  logic [7:0]  cfg_addr;
  logic [18:0] cfg_wdata;

  logic       in_ready0, out_valid0, out_class0, out_err0, cfg_busy0;
  logic [2:0] out_votes0;
  logic       in_ready1, out_valid1, out_class1, out_err1, cfg_busy1;
  logic [2:0] out_votes1;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  logic [18:0] shadow [256];
  int          m_phase;
  int          m_cnt;
  res_t        m_res;
  logic [2:0]  exp_votes;
  logic        exp_err, exp_c0, exp_c1;

  always #5 clk = ~clk;

  dtree_vote_engine #(.TIE_CLASS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_feat(in_feat),
    .out_valid(out_valid0), .out_ready(out_ready), .out_class(out_class0), .out_votes(out_votes0),
    .out_err(out_err0), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy0)
  );

  dtree_vote_engine #(.TIE_CLASS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_feat(in_feat),
    .out_valid(out_valid1), .out_ready(out_ready), .out_class(out_class1), .out_votes(out_votes1),
    .out_err(out_err1), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] mk(input bit leaf, input int fidx, input int lo, input int hi);
    node_t n;
    n.leaf = leaf;
    n.fidx = 6'(fidx);
    n.lo   = 6'(lo);
    n.hi   = 6'(hi);
    return n;
  endfunction

  function automatic logic cls(input int votes, input bit tie);
    if (votes * 2 > 4) return 1'b1;
    if (votes * 2 < 4) return 1'b0;
    return tie;
  endfunction

  // Walks every tree straight from the node-table rules; a write in the accept cycle is seen first.
  function automatic res_t evaluate(input logic [50:0] f, input bit we, input logic [7:0] wa,
                                    input logic [18:0] wd);
    res_t r;
    r.visits = 0;
    r.votes  = 0;
    r.err    = 1'b0;
    for (int t = 0; t < 4; t++) begin
      int node;
      node = 0;
      for (int s = 0; s < 16; s++) begin
        node_t n;
        int    idx;
        bit    b;
        idx = t * 64 + node;
        n   = (we && int'(wa) == idx) ? wd : shadow[idx];
        r.visits++;
        if (n.leaf) begin
          r.votes += int'(n.lo[0]);
          break;
        end
        if (s == 15) begin
          r.err = 1'b1;
          break;
        end
        b    = (int'(n.fidx) < 51) ? f[n.fidx] : 1'b0;
        node = b ? int'(n.hi) : int'(n.lo);
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase   <= 0;
      m_cnt     <= 0;
      exp_votes <= '0;
      exp_err   <= 1'b0;
      exp_c0    <= 1'b0;
      exp_c1    <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (cfg_we) shadow[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            m_res   <= evaluate(in_feat, cfg_we, cfg_addr, cfg_wdata);
            m_cnt   <= 0;
            m_phase <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt + 1 == m_res.visits) begin
            m_phase   <= 2;
            exp_votes <= 3'(m_res.votes);
            exp_err   <= m_res.err;
            exp_c0    <= cls(m_res.votes, 1'b0);
            exp_c1    <= cls(m_res.votes, 1'b1);
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("in_ready0",  in_ready0,  m_phase == 0);
      check("in_ready1",  in_ready1,  m_phase == 0);
      check("cfg_busy0",  cfg_busy0,  m_phase != 0);
      check("out_valid0", out_valid0, m_phase == 2);
      check("out_valid1", out_valid1, m_phase == 2);
      check("out_votes0", out_votes0, exp_votes);
      check("out_votes1", out_votes1, exp_votes);
      check("out_err0",   out_err0,   exp_err);
      check("out_class0", out_class0, exp_c0);
      check("out_class1", out_class1, exp_c1);
    end
  end

  task automatic cfg_write(input int tree, input int node, input logic [18:0] word);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 8'(tree * 64 + node);
    cfg_wdata = word;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run(input string tag, input logic [50:0] f, input bit wr_now, input logic [18:0] wd,
                     input bit wr_walk, input int hold, input int lat_e, input int votes_e,
                     input bit c0_e, input bit c1_e, input bit err_e);
    int cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = f;
    if (wr_now) begin
      cfg_we    = 1'b1;
      cfg_addr  = 8'hC0;
      cfg_wdata = wd;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    cyc      = 0;
    while (!out_valid0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (wr_walk && cyc == 2) begin
        cfg_we    = 1'b1;
        cfg_addr  = 8'hC0;
        cfg_wdata = wd;
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
    check({tag, "_latency"}, cyc, lat_e);
    check({tag, "_votes"}, out_votes0, votes_e);
    check({tag, "_class_tie0"}, out_class0, c0_e);
    check({tag, "_class_tie1"}, out_class1, c1_e);
    check({tag, "_err"}, out_err0, err_e);
    check({tag, "_model_votes"}, m_res.votes, votes_e);
    repeat (hold) @(negedge clk);
    check({tag, "_held_valid"}, out_valid0, 1'b1);
    check({tag, "_held_ready"}, in_ready0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, in_ready0, 1'b1);
  endtask

  initial begin
    logic [50:0] f;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_feat   = '0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    checking = 1'b1;
    check("reset_out_valid", out_valid0, 1'b0);
    check("reset_in_ready", in_ready0, 1'b1);
    check("reset_cfg_busy", cfg_busy0, 1'b0);
    check("reset_votes", out_votes0, 3'd0);
    check("reset_class", out_class0, 1'b0);
    check("reset_err", out_err0, 1'b0);

    // Four single-leaf trees voting 1.
    for (int t = 0; t < 4; t++) cfg_write(t, 0, mk(1, 0, 1, 0));
    f = 51'({$urandom, $urandom});
    run("all_leaf1", f, 0, '0, 0, 0, 4, 4, 1, 1, 0);

    // Tree 0 splits on feature 50; the rest are class-0 leaves.
    cfg_write(0, 0, mk(0, 50, 1, 2));
    cfg_write(0, 1, mk(1, 0, 0, 0));
    cfg_write(0, 2, mk(1, 0, 1, 0));
    for (int t = 1; t < 4; t++) cfg_write(t, 0, mk(1, 0, 0, 0));
    f = 51'(1) << 50;
    run("split_hi", f, 0, '0, 0, 0, 5, 1, 0, 0, 0);
    f = ~(51'(1) << 50);
    run("split_lo", f, 0, '0, 0, 0, 5, 0, 0, 0, 0);

    // Tie: tree 3 is rewritten to class 0 in the accept cycle, leaving two votes of four.
    cfg_write(0, 0, mk(1, 0, 1, 0));
    cfg_write(1, 0, mk(1, 0, 1, 0));
    cfg_write(2, 0, mk(1, 0, 0, 0));
    cfg_write(3, 0, mk(1, 0, 1, 0));
    run("tie_wr_accept", 51'h5_5555_5555_5555, 1, mk(1, 0, 0, 0), 0, 0, 4, 2, 0, 1, 0);

    // Tree 2 self-loops and aborts; a write during the walk must be dropped.
    cfg_write(2, 0, mk(0, 3, 0, 0));
    cfg_write(3, 0, mk(1, 0, 1, 0));
    run("abort_busy_wr", 51'h1_2345_6789_ABCD, 0, mk(1, 0, 0, 0), 1, 10, 19, 3, 1, 1, 1);
    run("abort_rerun", 51'h7_FFFF_0000_FFFF, 0, '0, 0, 0, 19, 3, 1, 1, 1);

    // Reset in the middle of a walk discards it; the table survives.
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = 51'h0_0F0F_0F0F_0F0F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midwalk_rst_valid", out_valid0, 1'b0);
    check("midwalk_rst_ready", in_ready0, 1'b1);
    #1 rst = 1'b0;
    run("after_reset", 51'h3_0000_0000_0001, 0, '0, 0, 0, 19, 3, 1, 1, 1);

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
